// File: rtl/mau_pkg.sv
// Shared constants for the memory access unit: funct3 access sizes and FSM state encoding.
package mau_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: legality/alignment check, byte enables, store lane replication, load extract/extend.
// Zero latency; no flow control of its own.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic        o_ok,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic        w_legal;
  logic        w_aligned;
  logic [31:0] w_shift;

  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    o_be      = 4'b0000;
    o_wdata   = 32'h0;
    // Asserting LOAD and STORE together is never legal.
    if (i_load && !i_store) begin
      w_legal = (i_funct3 == MEM_B) || (i_funct3 == MEM_H) || (i_funct3 == MEM_W) ||
                (i_funct3 == MEM_BU) || (i_funct3 == MEM_HU);
    end else if (i_store && !i_load) begin
      w_legal = (i_funct3 == MEM_B) || (i_funct3 == MEM_H) || (i_funct3 == MEM_W);
    end
    case (i_funct3)
      MEM_B, MEM_BU: begin
        w_aligned = 1'b1;
        o_be      = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        w_aligned = ~i_addr_lo[0];
        o_be      = 4'b0011 << i_addr_lo;
        o_wdata   = {2{i_wdata[15:0]}};
      end
      MEM_W: begin
        w_aligned = (i_addr_lo == 2'b00);
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
      end
      default: begin
        w_aligned = 1'b0;
      end
    endcase
    o_ok = w_legal && w_aligned;
  end

  always_comb begin
    w_shift = i_rdata >> {i_addr_lo, 3'b000};
    case (i_funct3)
      MEM_B:   o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
      MEM_H:   o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
      MEM_BU:  o_rdata = {24'h0, w_shift[7:0]};
      MEM_HU:  o_rdata = {16'h0, w_shift[15:0]};
      MEM_W:   o_rdata = i_rdata;
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mau.sv
// Memory access unit: one valid/ack bus transaction per LOAD/STORE, 3 cycles minimum plus bus wait states.
// Holds the pipeline with stall until DONE; abandons the access after BUS_TIMEOUT unacked REQ cycles.
module mau
  import mau_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_LOAD,
  input  logic        riscv_STORE,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_toMAU,
  input  logic [31:0] data_toMAU,
  output logic [31:0] data_fromMAU,
  output logic        load_valid,
  output logic        stall,
  output logic        misalign,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_load;

  logic              w_req;
  logic              w_idle;
  logic              w_al_load;
  logic              w_al_store;
  logic [2:0]        w_al_funct3;
  logic [1:0]        w_al_addr_lo;
  logic              w_ok;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_rdata;
  logic              w_accept;
  logic              w_timeout;

  // One aligner serves both phases: live inputs while IDLE, latched access while in REQ.
  assign w_idle       = (r_state == IDLE);
  assign w_req        = riscv_LOAD || riscv_STORE;
  assign w_al_load    = w_idle ? riscv_LOAD : r_load;
  assign w_al_store   = w_idle ? riscv_STORE : !r_load;
  assign w_al_funct3  = w_idle ? funct3 : r_funct3;
  assign w_al_addr_lo = w_idle ? addr_toMAU[1:0] : r_addr_lo;

  mau_lane_align u_lane_align (
    .i_load    (w_al_load),
    .i_store   (w_al_store),
    .i_funct3  (w_al_funct3),
    .i_addr_lo (w_al_addr_lo),
    .i_wdata   (data_toMAU),
    .i_rdata   (bus_rdata),
    .o_ok      (w_ok),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata)
  );

  assign w_accept  = w_idle && w_req && w_ok;
  assign w_timeout = (r_state == REQ) && !bus_ack && (r_cnt == CNT_W'(BUS_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      IDLE: begin
        stall = w_accept;
        if (w_accept) w_next = REQ;
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack || w_timeout) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_funct3     <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_load       <= 1'b0;
      data_fromMAU <= 32'h0;
      load_valid   <= 1'b0;
      misalign     <= 1'b0;
      access_fault <= 1'b0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_be       <= 4'b0000;
      bus_wdata    <= 32'h0;
    end else begin
      r_state      <= w_next;
      misalign     <= w_idle && w_req && !w_ok;
      access_fault <= w_timeout;
      load_valid   <= (r_state == REQ) && bus_ack && r_load;
      if (w_accept) begin
        r_cnt     <= '0;
        r_funct3  <= funct3;
        r_addr_lo <= addr_toMAU[1:0];
        r_load    <= riscv_LOAD;
        bus_req   <= 1'b1;
        bus_we    <= riscv_STORE;
        bus_addr  <= {addr_toMAU[31:2], 2'b00};
        bus_be    <= w_be;
        bus_wdata <= w_wdata;
      end else if (r_state == REQ) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (bus_ack || w_timeout) bus_req <= 1'b0;
        if (bus_ack && r_load) data_fromMAU <= w_rdata;
      end
    end
  end

endmodule

// File: doc/mau.md
# mau

Memory access unit sitting directly downstream of the ALU: it takes the effective address and store data the ALU computes for LOAD/STORE instructions, runs one valid/ack transaction on the data bus, and returns aligned, sign- or zero-extended load data on `data_fromMAU`. It checks alignment and size, drives byte enables, and stalls the pipeline until the access completes.

## Interface
- `BUS_TIMEOUT`, 16: cycles in REQ without `bus_ack` before the access is abandoned with `access_fault`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `riscv_LOAD` in 1: the current instruction is a load.
- `riscv_STORE` in 1: the current instruction is a store.
- `funct3` in 3: access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `addr_toMAU` in 32: effective byte address from the ALU (0 when not LOAD/STORE).
- `data_toMAU` in 32: store data from the ALU, unshifted, in low bits.
- `data_fromMAU` out 32: last completed load result, extended to 32 bits.
- `load_valid` out 1: one-cycle pulse, `data_fromMAU` updated this cycle.
- `stall` out 1: pipeline must hold the current instruction.
- `misalign` out 1: one-cycle pulse, misaligned address or illegal funct3.
- `access_fault` out 1: one-cycle pulse, bus timeout.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned, bits [1:0]=0), `bus_be` out 4, `bus_wdata` out 32: request side.
- `bus_ack` in 1, `bus_rdata` in 32: response side; `bus_rdata` valid only with `bus_ack`.

## Operation
- States IDLE, REQ, DONE.
- IDLE, `riscv_LOAD|riscv_STORE` high:
  - legal and aligned: latch the address, funct3, `we`, lane-shifted wdata and `be`; go to REQ. `stall` is 1 combinationally this cycle.
  - otherwise: pulse `misalign` next cycle, issue no bus access, stay in IDLE, keep `stall` 0.
- Legal: LOAD funct3 ∈ {000,001,010,100,101}; STORE funct3 ∈ {000,001,010}.
- Aligned: halfword needs addr[0]=0; word needs addr[1:0]=0.
- Both LOAD and STORE high at once: treat as illegal and pulse `misalign`.
- REQ:
  - `bus_req`=1; `bus_addr`, `bus_we`, `bus_be`, `bus_wdata` are held stable.
  - A timeout counter increments each cycle.
  - On `bus_ack`: a load extracts the lane and extends it into `data_fromMAU`; go to DONE.
  - Counter reaching `BUS_TIMEOUT` without an ack: drop `bus_req`, pulse `access_fault`, leave `data_fromMAU` unchanged, go to DONE.
- DONE:
  - `stall`=0 so the pipeline advances on this edge.
  - `load_valid`=1 only if a load completed with an ack.
  - Inputs are ignored; next state is IDLE.
- Store lanes:
  - SB: `be`=0001<<addr[1:0], wdata={4{byte}}.
  - SH: `be`=0011<<addr[1:0], wdata={2{half}}.
  - SW: `be`=1111.
- Load extract: `bus_rdata` >> 8·addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Stores never modify `data_fromMAU`.

## Timing
- Reset values (`reset`=0 on an edge): state IDLE, counter 0, every output 0 including `data_fromMAU`.
- Reset mid-REQ drops `bus_req` the next cycle; the bus side tolerates an abandoned request.
- Minimum access takes 3 cycles: accept (IDLE), REQ with same-cycle `bus_ack`, DONE.
- N wait states add N cycles.
- `bus_req` is registered; `stall` is combinational in IDLE and registered-state-based otherwise.
- `misalign` and `access_fault` are registered pulses, exactly one cycle each.
- A `bus_ack` arriving in IDLE or DONE is ignored.
- The timeout counter width is clog2(`BUS_TIMEOUT`+1).

## Structure
- The shared package holds:
  - the funct3 size constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - the state encoding (IDLE, REQ, DONE).
- One combinational sub-module, `mau_lane_align`, does store lane replication, `be` generation, load extraction/extension and the legality/alignment check; it is used by `mau` both at accept and at ack.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, ack in REQ -> `bus_addr`=0x100, `be`=1111, `wdata`=0xDEADBEEF, `stall` high 2 cycles, no `load_valid`.
- LB addr 0x103, `bus_rdata`=0x80FF_0000 -> `data_fromMAU`=0xFFFFFF80, `load_valid` one cycle; same read with LBU -> 0x00000080.
- SH addr 0x202, data 0x1234 -> `be`=1100, `wdata`=0x12341234; LH addr 0x201 -> `misalign` pulse, no `bus_req`, `stall` 0.
- LW with `bus_ack` withheld -> `bus_req` drops after 16 cycles, `access_fault` pulses, `data_fromMAU` holds its old value, back to IDLE.
- LW with 3 wait states then ack of 0xCAFEF00D -> `stall` high 5 cycles total, `data_fromMAU`=0xCAFEF00D.
- `reset`=0 during REQ -> next cycle all outputs 0; a new LW after reset completes normally.
